// File: rtl/param_proc_core.sv
// rtl/param_proc_core.sv - multi-cycle register-file datapath core with valid/ready instruction intake
//
// Purpose:
//   Executes one instruction at a time through a small control FSM
//   (IDLE -> T1 -> [T2 -> T3] -> DONE). The register file, the A and G
//   registers and the ALU all exchange data over a single internal bus.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   instr_valid/instr_ready  instruction handshake; ready only while IDLE
//   instr_op/rx/ry/imm       instruction fields, latched on acceptance
//   done, err                one-cycle retire pulse; err marks an illegal opcode
//   busy                     high whenever the FSM is not IDLE
//   flag_c, flag_z           carry/borrow and zero from the last ALU operation
//   dbg_sel, dbg_data        registered view of R[dbg_sel]
module param_proc_core #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        instr_op,
  input  logic [REG_AW-1:0] instr_rx,
  input  logic [REG_AW-1:0] instr_ry,
  input  logic [DATA_W-1:0] instr_imm,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic              flag_c,
  output logic              flag_z,
  input  logic [REG_AW-1:0] dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int NUM_REGS = 2**REG_AW;

  localparam logic [3:0] OP_LOAD = 4'd1;
  localparam logic [3:0] OP_MOV  = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_AND  = 4'd6;
  localparam logic [3:0] OP_OR   = 4'd7;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic [REG_AW-1:0]  rx_q, rx_d;
  logic [REG_AW-1:0]  ry_q, ry_d;
  logic [DATA_W-1:0]  imm_q, imm_d;
  logic [DATA_W-1:0]  a_q, a_d;
  logic [DATA_W-1:0]  g_q, g_d;
  logic               flag_c_q, flag_c_d;
  logic               flag_z_q, flag_z_d;
  logic [DATA_W-1:0]  regs_q [NUM_REGS];
  logic [DATA_W-1:0]  regs_d [NUM_REGS];
  logic               ready_q, ready_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic [DATA_W-1:0]  dbg_q, dbg_d;

  logic               accept;
  logic               is_alu;
  logic               is_illegal;
  logic [DATA_W-1:0]  rhs;
  logic [DATA_W:0]    sum;
  logic [DATA_W-1:0]  alu_res;
  logic               alu_c;
  logic [DATA_W-1:0]  bus;
  logic               wr_en;

  assign accept     = instr_valid & ready_q;
  assign is_alu     = (op_q >= OP_ADD) && (op_q <= OP_OR);
  assign is_illegal = op_q[3];
  assign rhs        = regs_q[ry_q];

  // ALU: operand A comes from the A register, operand B straight from R[ry]
  always_comb begin
    sum     = {1'b0, a_q} + {1'b0, rhs};
    alu_res = '0;
    alu_c   = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_res = sum[DATA_W-1:0];
        alu_c   = sum[DATA_W];
      end
      OP_SUB: begin
        alu_res = a_q - rhs;
        alu_c   = (a_q < rhs);
      end
      OP_XOR:  alu_res = a_q ^ rhs;
      OP_AND:  alu_res = a_q & rhs;
      OP_OR:   alu_res = a_q | rhs;
      default: alu_res = '0;
    endcase
  end

  // Internal bus: one source per state; the register file only writes from the bus
  always_comb begin
    bus   = '0;
    wr_en = 1'b0;
    case (state_q)
      S_T1: begin
        if (op_q == OP_LOAD) begin
          bus   = imm_q;
          wr_en = 1'b1;
        end else if (op_q == OP_MOV) begin
          bus   = rhs;
          wr_en = 1'b1;
        end else if (is_alu) begin
          bus = regs_q[rx_q];
        end
      end
      S_T3: begin
        bus   = g_q;
        wr_en = 1'b1;
      end
      default: bus = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rx_d     = rx_q;
    ry_d     = ry_q;
    imm_d    = imm_q;
    a_d      = a_q;
    g_d      = g_q;
    flag_c_d = flag_c_q;
    flag_z_d = flag_z_q;
    regs_d   = regs_q;

    if (wr_en) regs_d[rx_q] = bus;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = instr_op;
          rx_d    = instr_rx;
          ry_d    = instr_ry;
          imm_d   = instr_imm;
          state_d = S_T1;
        end
      end
      S_T1: begin
        if (is_alu) begin
          a_d     = bus;
          state_d = S_T2;
        end else begin
          state_d = S_DONE;
        end
      end
      S_T2: begin
        g_d      = alu_res;
        flag_c_d = alu_c;
        flag_z_d = (alu_res == '0);
        state_d  = S_T3;
      end
      S_T3:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered, so they are derived from the next state
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    err_d   = (state_d == S_DONE) && is_illegal;
    // Sampled from the current file: shows the pre-write value on a write edge
    dbg_d   = regs_q[dbg_sel];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      rx_q     <= '0;
      ry_q     <= '0;
      imm_q    <= '0;
      a_q      <= '0;
      g_q      <= '0;
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      dbg_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rx_q     <= rx_d;
      ry_q     <= ry_d;
      imm_q    <= imm_d;
      a_q      <= a_d;
      g_q      <= g_d;
      flag_c_q <= flag_c_d;
      flag_z_q <= flag_z_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
      ready_q  <= ready_d;
      done_q   <= done_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      dbg_q    <= dbg_d;
    end
  end

  assign instr_ready = ready_q;
  assign done        = done_q;
  assign err         = err_q;
  assign busy        = busy_q;
  assign flag_c      = flag_c_q;
  assign flag_z      = flag_z_q;
  assign dbg_data    = dbg_q;

endmodule

// File: tb/tb_param_proc_core.sv
// tb/tb_param_proc_core.sv - self-checking bench for param_proc_core against an arithmetic reference model
module tb_param_proc_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  instr_op;
  logic [2:0]  instr_rx;
  logic [2:0]  instr_ry;
  logic [15:0] instr_imm;
  logic        done;
  logic        err;
  logic        busy;
  logic        flag_c;
  logic        flag_z;
  logic [2:0]  dbg_sel;
  logic [15:0] dbg_data;

  param_proc_core #(.DATA_W(16), .REG_AW(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_op    (instr_op),
    .instr_rx    (instr_rx),
    .instr_ry    (instr_ry),
    .instr_imm   (instr_imm),
    .done        (done),
    .err         (err),
    .busy        (busy),
    .flag_c      (flag_c),
    .flag_z      (flag_z),
    .dbg_sel     (dbg_sel),
    .dbg_data    (dbg_data)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] m_r [8];
  logic        m_c;
  logic        m_z;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_r[i] = 16'h0;
    m_c = 1'b0;
    m_z = 1'b0;
  endtask

  // Reference semantics written directly from the instruction set definitions
  task automatic model_exec(input logic [3:0] op, input int rx, input int ry, input logic [15:0] imm);
    int a, b, s;
    a = int'(m_r[rx]);
    b = int'(m_r[ry]);
    s = 0;
    case (op)
      4'd1: m_r[rx] = imm;
      4'd2: m_r[rx] = m_r[ry];
      4'd3, 4'd4, 4'd5, 4'd6, 4'd7: begin
        case (op)
          4'd3:    s = a + b;
          4'd4:    s = a - b;
          4'd5:    s = a ^ b;
          4'd6:    s = a & b;
          default: s = a | b;
        endcase
        if (op == 4'd3)      m_c = (s > 65535);
        else if (op == 4'd4) m_c = (a < b);
        else                 m_c = 1'b0;
        m_r[rx] = s[15:0];
        m_z     = (s[15:0] == 16'h0);
      end
      default: ;
    endcase
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 8; i++) begin
      dbg_sel = 3'(i);
      @(negedge clk);
      check_eq($sformatf("%s_r%0d", tag, i), dbg_data, m_r[i]);
    end
  endtask

  task automatic check_reg(input string tag, input int r, input logic [15:0] exp);
    dbg_sel = 3'(r);
    repeat (2) @(negedge clk);
    check_eq(tag, dbg_data, exp);
  endtask

  // Called on a negedge with the core idle; returns on a negedge with the core idle
  task automatic run_instr(input logic [3:0] op, input int rx, input int ry,
                           input logic [15:0] imm, input string tag);
    int   cyc, lat, exp_lat;
    logic exp_err;
    exp_lat = (op >= 4'd3 && op <= 4'd7) ? 4 : 2;
    exp_err = op[3];
    instr_op    = op;
    instr_rx    = 3'(rx);
    instr_ry    = 3'(ry);
    instr_imm   = imm;
    instr_valid = 1'b1;
    cyc = 0;
    while (instr_ready !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check_eq({tag, "_ready"}, instr_ready, 1);
    model_exec(op, rx, ry, imm);
    @(negedge clk);
    // fields are don't-care once accepted
    instr_valid = 1'b0;
    instr_op    = 4'($urandom);
    instr_rx    = 3'($urandom);
    instr_ry    = 3'($urandom);
    instr_imm   = 16'($urandom);
    lat = 1;
    while (done !== 1'b1 && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    check_eq({tag, "_lat"}, lat, exp_lat);
    check_eq({tag, "_err"}, err, exp_err);
    check_eq({tag, "_flags"}, {flag_c, flag_z}, {m_c, m_z});
    dbg_sel = 3'(rx);
    @(negedge clk);
    check_eq({tag, "_done_pulse"}, done, 0);
    check_eq({tag, "_reg"}, dbg_data, m_r[rx]);
  endtask

  localparam int N_STREAM = 12;
  logic [3:0] s_op [N_STREAM];
  logic [2:0] s_rx [N_STREAM];
  logic [2:0] s_ry [N_STREAM];

  initial begin
    int idx, dones, cyc, last_acc;
    bit pending;
    logic [3:0] rop;

    rst = 1'b0;
    instr_valid = 1'b0;
    instr_op = '0;
    instr_rx = '0;
    instr_ry = '0;
    instr_imm = '0;
    dbg_sel = '0;
    model_clear();
    repeat (2) @(negedge clk);
    check_eq("rst_ready", instr_ready, 1);
    check_eq("rst_busy_done_err", {busy, done, err}, 3'b000);
    check_eq("rst_flags", {flag_c, flag_z}, 2'b00);
    rst = 1'b1;
    @(negedge clk);
    check_all("rst");

    run_instr(4'd1, 3, 0, 16'h1234, "load_r3");
    check_reg("load_r3_val", 3, 16'h1234);

    run_instr(4'd1, 0, 0, 16'hFFFF, "load_r0");
    run_instr(4'd1, 1, 0, 16'h0001, "load_r1");
    run_instr(4'd3, 0, 1, 16'h0, "add_r0_r1");
    check_eq("add_wrap_cz", {flag_c, flag_z}, 2'b11);
    check_reg("add_wrap_r0", 0, 16'h0000);

    run_instr(4'd1, 2, 0, 16'd5, "load_r2");
    run_instr(4'd1, 4, 0, 16'd7, "load_r4");
    run_instr(4'd4, 2, 4, 16'h0, "sub_r2_r4");
    check_eq("sub_borrow_cz", {flag_c, flag_z}, 2'b10);
    check_reg("sub_borrow_r2", 2, 16'hFFFE);

    run_instr(4'd3, 1, 1, 16'h0, "add_r1_r1");
    check_reg("add_self_r1", 1, 16'h0002);
    run_instr(4'd4, 1, 1, 16'h0, "sub_r1_r1");
    check_eq("sub_self_cz", {flag_c, flag_z}, 2'b01);

    run_instr(4'd9, 3, 2, 16'hBEEF, "illegal9");
    check_all("illegal9");

    for (int k = 0; k < 40; k++) begin
      rop = 4'($urandom_range(0, 10));
      run_instr(rop, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                16'($urandom), $sformatf("rnd%0d_op%0d", k, rop));
    end
    check_all("rnd");

    // Streaming: instr_valid held high across a series of MOV/XOR instructions
    for (int k = 0; k < N_STREAM; k++) begin
      s_op[k] = ($urandom_range(0, 1) == 0) ? 4'd2 : 4'd5;
      s_rx[k] = 3'($urandom);
      s_ry[k] = 3'($urandom);
    end
    idx = 0;
    dones = 0;
    cyc = 0;
    last_acc = 0;
    pending = 1'b0;
    instr_op = s_op[0];
    instr_rx = s_rx[0];
    instr_ry = s_ry[0];
    instr_valid = 1'b1;
    while (dones < N_STREAM && cyc < 400) begin
      if (done === 1'b1) dones++;
      if (busy === 1'b1) check_eq("stream_ready_busy", instr_ready, 0);
      if (instr_valid && instr_ready === 1'b1) begin
        if (idx > 0)
          check_eq("stream_gap", cyc - last_acc, (s_op[idx-1] == 4'd2) ? 3 : 5);
        last_acc = cyc;
        model_exec(s_op[idx], int'(s_rx[idx]), int'(s_ry[idx]), 16'h0);
        idx++;
        pending = 1'b1;
      end
      @(negedge clk);
      cyc++;
      if (pending) begin
        pending = 1'b0;
        if (idx < N_STREAM) begin
          instr_op = s_op[idx];
          instr_rx = s_rx[idx];
          instr_ry = s_ry[idx];
        end else begin
          instr_valid = 1'b0;
        end
      end
    end
    check_eq("stream_dones", dones, N_STREAM);
    check_eq("stream_accepts", idx, N_STREAM);
    @(negedge clk);
    check_eq("stream_no_extra_done", done, 0);
    check_eq("stream_flags", {flag_c, flag_z}, {m_c, m_z});
    check_all("stream");

    // Reset asserted while an ADD sits in T2
    run_instr(4'd1, 5, 0, 16'hABCD, "load_r5");
    instr_op = 4'd3;
    instr_rx = 3'd5;
    instr_ry = 3'd5;
    instr_valid = 1'b1;
    check_eq("midrst_ready", instr_ready, 1);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("midrst_async", {busy, done, instr_ready}, 3'b001);
    repeat (2) begin
      @(negedge clk);
      check_eq("midrst_no_done", done, 0);
    end
    rst = 1'b1;
    model_clear();
    repeat (3) begin
      @(negedge clk);
      check_eq("midrst_after_done", done, 0);
    end
    check_eq("midrst_flags", {flag_c, flag_z}, 2'b00);
    check_all("midrst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
